// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// MC_CTRL_ILLEGAL_TRAP_EN adds the HALT state for unsupported opcodes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXECUTE,
        S_ALU_WB,
        S_BRANCH,
        S_JUMP,
        S_IMM_EXEC,
        S_IMM_WB
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        ,
        S_HALT
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b101;
    localparam logic [2:0] ALU_ADDI  = 3'b110;
    localparam logic [2:0] ALU_OR    = 3'b111;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef struct packed {
        logic mem;
        logic rtype;
        logic branch;
        logic jump;
        logic imm;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle FSM and the datapath.
// master = controller side, slave = datapath side.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemToReg;
    logic       IRWrite;
    logic [1:0] PCSource;
    logic [2:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic       RegDST;
    logic       instr_done;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
        output MemToReg, IRWrite, PCSource, ALUOp, ALUSrcA,
        output ALUSrcB, RegWrite, RegDST, instr_done
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
        input  MemToReg, IRWrite, PCSource, ALUOp, ALUSrcA,
        input  ALUSrcB, RegWrite, RegDST, instr_done
    );
endinterface

// File: rtl/mc_opcode_class.sv
// Opcode to instruction-class decode, one-hot, used by DECODE.
module mc_opcode_class
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  cls
);

    // one-hot class from the supported opcode set
    always_comb begin
        cls = '0;
        unique case (1'b1)
            (opcode == OP_LW) || (opcode == OP_SW): cls.mem = 1'b1;
            (opcode == OP_RTYPE):                   cls.rtype = 1'b1;
            (opcode == OP_BEQ):                     cls.branch = 1'b1;
            (opcode == OP_J):                       cls.jump = 1'b1;
            (opcode == OP_ANDI) || (opcode == OP_ADDI)
                || (opcode == OP_ORI):              cls.imm = 1'b1;
            default:                                cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencing FSM for the multicycle MIPS datapath.
// MC_CTRL_ILLEGAL_TRAP_EN: unsupported opcodes halt until reset.
module multicycle_control
    import mc_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_t    state;
    state_t    state_nxt;
    op_class_t cls;

    mc_opcode_class u_class (
        .opcode (bus.opcode),
        .cls    (cls)
    );

    // state register, reset returns to FETCH
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    // next state and control outputs, all zero while in reset
    always_comb begin
        state_nxt       = state;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemToReg    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.PCSource    = PCS_ALU;
        bus.ALUOp       = ALU_ADD;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = SRCB_B;
        bus.RegWrite    = 1'b0;
        bus.RegDST      = 1'b0;
        bus.instr_done  = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = SRCB_FOUR;
                    bus.IRWrite = bus.mem_ready;
                    bus.PCWrite = bus.mem_ready;
                    if (bus.mem_ready) state_nxt = S_DECODE;
                end
                S_DECODE: begin
                    bus.ALUSrcB = SRCB_IMM_SH;
                    unique case (1'b1)
                        cls.mem:    state_nxt = S_MEM_ADDR;
                        cls.rtype:  state_nxt = S_EXECUTE;
                        cls.branch: state_nxt = S_BRANCH;
                        cls.jump:   state_nxt = S_JUMP;
                        cls.imm:    state_nxt = S_IMM_EXEC;
                        cls.illegal: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                            state_nxt = S_HALT;
`else
                            bus.instr_done = 1'b1;
                            state_nxt      = S_FETCH;
`endif
                        end
                        default:    state_nxt = S_FETCH;
                    endcase
                end
                S_MEM_ADDR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = SRCB_IMM;
                    state_nxt   = (bus.opcode == OP_LW) ?
                                  S_MEM_READ : S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                    if (bus.mem_ready) state_nxt = S_MEM_WB;
                end
                S_MEM_WB: begin
                    bus.MemToReg   = 1'b1;
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                    state_nxt      = S_FETCH;
                end
                S_MEM_WRITE: begin
                    bus.MemWrite   = 1'b1;
                    bus.IorD       = 1'b1;
                    bus.instr_done = bus.mem_ready;
                    if (bus.mem_ready) state_nxt = S_FETCH;
                end
                S_EXECUTE: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = ALU_FUNCT;
                    state_nxt   = S_ALU_WB;
                end
                S_ALU_WB: begin
                    bus.RegDST     = 1'b1;
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                    state_nxt      = S_FETCH;
                end
                S_BRANCH: begin
                    bus.ALUSrcA     = 1'b1;
                    bus.ALUOp       = ALU_SUB;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSource    = PCS_ALUOUT;
                    bus.instr_done  = 1'b1;
                    state_nxt       = S_FETCH;
                end
                S_JUMP: begin
                    bus.PCWrite    = 1'b1;
                    bus.PCSource   = PCS_JUMP;
                    bus.instr_done = 1'b1;
                    state_nxt      = S_FETCH;
                end
                S_IMM_EXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = SRCB_IMM;
                    case (bus.opcode)
                        OP_ANDI: bus.ALUOp = ALU_AND;
                        OP_ORI:  bus.ALUOp = ALU_OR;
                        default: bus.ALUOp = ALU_ADDI;
                    endcase
                    state_nxt = S_IMM_WB;
                end
                S_IMM_WB: begin
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                    state_nxt      = S_FETCH;
                end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                S_HALT: state_nxt = S_HALT;
`endif
                default: state_nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multicycle MIPS datapath: a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back cycles. It drives the shared-ALU, single-memory datapath's mux selects and write enables, and stalls on a memory ready handshake. Supported opcodes: R-type (ADD/SUB/OR/AND/SLT), LW, SW, BEQ, J, ANDI, ADDI, ORI. It sits beside the datapath and replaces single-cycle decode when the core is built multicycle.

## Interface
Parameters: none.
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]; valid from DECODE onward, stable until next FETCH completes
- mem_ready  in  1  memory completed the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero (BEQ)
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- MemToReg  out  1  write-back data: 0 = ALUOut, 1 = MDR
- IRWrite  out  1  load instruction register
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUOp  out  3  000 add, 001 sub, 010 funct-decode, 101 and, 110 add-imm, 111 or
- ALUSrcA  out  1  0 = PC, 1 = rs register (A)
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- RegWrite  out  1  register file write
- RegDST  out  1  destination: 0 = rt, 1 = rd
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH, JUMP, IMM_EXEC, IMM_WB (plus HALT, see Configuration).
- Outputs not listed for a state are 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00. IRWrite and PCWrite = mem_ready. Advance to DECODE only when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (precompute branch target).
  - LW/SW -> MEM_ADDR; R-type -> EXECUTE; BEQ -> BRANCH; J -> JUMP; ANDI/ADDI/ORI -> IMM_EXEC.
  - Any other opcode -> FETCH with instr_done=1 (NOP).
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. LW -> MEM_READ; SW -> MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Go to MEM_WB when mem_ready=1.
- MEM_WB: RegDST=0, MemToReg=1, RegWrite=1, instr_done=1. Go to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. On mem_ready=1: instr_done=1, go to FETCH; otherwise hold.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Go to ALU_WB.
- ALU_WB: RegDST=1, MemToReg=0, RegWrite=1, instr_done=1. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01, instr_done=1. Go to FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Go to FETCH.
- IMM_EXEC: ALUSrcA=1, ALUSrcB=10. ALUOp = 101 (ANDI), 110 (ADDI), 111 (ORI). Go to IMM_WB.
- IMM_WB: RegDST=0, MemToReg=0, RegWrite=1, instr_done=1. Go to FETCH.
- No X is ever driven on any output; don't-cares are 0.

## Timing
- Reset: while reset=1, all outputs are 0 and state is forced to FETCH. The first fetch request is on the first cycle after reset deasserts. Reset in any state aborts the instruction with no write issued on the next cycle.
- Cycles with mem_ready=1 every access: BEQ/J 3; R-type, SW, ANDI/ADDI/ORI 4; LW 5; illegal 2.
- Each cycle mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. Request outputs hold steady during a stall.
- mem_ready is ignored in all other states.
- Outputs are a function of state only, except IRWrite/PCWrite in FETCH and instr_done in MEM_WRITE, which are qualified by mem_ready.

## Configuration
- MC_CTRL_ILLEGAL_TRAP_EN defined: an unsupported opcode in DECODE enters HALT. HALT holds all outputs at 0, never pulses instr_done, and is exited only by reset.
- MC_CTRL_ILLEGAL_TRAP_EN undefined: the HALT state does not exist, and an unsupported opcode behaves as a 2-cycle NOP.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum;
  - opcode constants (OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_BEQ 000100, OP_J 000010, OP_ANDI 001100, OP_ADDI 001000, OP_ORI 001101);
  - ALUOp constants and PCSource/ALUSrcB encodings.
- One sub-module, mc_opcode_class: combinational opcode-to-class decode (mem, rtype, branch, jump, imm, illegal), used for the DECODE transition.

## Test plan
- Reset held 3 cycles, released, mem_ready=1: all outputs 0 during reset; next cycle MemRead=1, IRWrite=1, PCWrite=1.
- opcode 000000, mem_ready=1: states FETCH, DECODE, EXECUTE(ALUOp=010), ALU_WB(RegWrite=1, RegDST=1). instr_done in cycle 4 only.
- opcode 100011, mem_ready low 2 cycles in MEM_READ: 7 total cycles; MemRead=1, IorD=1 held 3 cycles; MEM_WB gives MemToReg=1.
- opcode 000100, then 000010: BEQ gives PCWriteCond=1, PCSource=01 in cycle 3; J gives PCWrite=1, PCSource=10 in cycle 3.
- opcode 001101 and 001100: IMM_EXEC ALUOp=111 and 101 respectively; IMM_WB RegWrite=1, RegDST=0.
- opcode 111111, with and without MC_CTRL_ILLEGAL_TRAP_EN: without, back to FETCH with instr_done; with, outputs stay 0 until reset, then normal fetch.
